task_dispatcher: RTL

//  Consumer end of the sorted insertion queue: pops the head task (smallest key) whenever the

---
 rtl/task_dispatcher.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/task_dispatcher.sv
// -----------------------------------------------------------------------------
// task_dispatcher
//
// Consumer end of a sorted insertion queue. Whenever the output slot is free
// (or is being freed by a handshake this cycle) the head task (smallest key) is
// popped, held in a register and offered to the core with valid/ready.
// The block also generates the periodic aging pulse for the queue, ages the
// held task's key on that pulse, and flags tasks whose key has reached zero.
//
// Optional feature (compile-time macro DISPATCH_MISS_DROP_EN):
//   defined     - a popped task with key == 0 is counted in miss_cnt and
//                 discarded; it is never offered to the core.
//   not defined - expired tasks are offered normally with task_expired = 1;
//                 miss_cnt still counts them.
//
// Parameters
//   W         queue entry width including its valid bit; task word is W-1 bits
//   KEY_W     low KEY_W bits of a task hold the remaining-time key
//   TICK_DIV  cycles per aging pulse (>= 2)
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous, active-low reset
//   enable        in   1 = pops allowed; 0 = no new pops, held task still offered
//   q_data        in   queue head task (combinational from the queue)
//   q_empty       in   queue empty
//   q_rd          out  one-cycle pop pulse to the queue
//   q_subtract    out  one-cycle aging pulse to the queue
//   task_data     out  held task
//   task_valid    out  task_data valid
//   task_ready    in   core accepts the task when task_valid & task_ready
//   task_expired  out  held task key == 0 (only with task_valid)
//   miss_cnt      out  number of expired tasks popped, saturating
// -----------------------------------------------------------------------------
module task_dispatcher #(
  parameter int W        = 41,
  parameter int KEY_W    = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [W-2:0]   q_data,
  input  logic           q_empty,
  output logic           q_rd,
  output logic           q_subtract,
  output logic [W-2:0]   task_data,
  output logic           task_valid,
  input  logic           task_ready,
  output logic           task_expired,
  output logic [15:0]    miss_cnt
);

  localparam int TW    = W - 1;
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic [TW-1:0]     r_task;
  logic [15:0]       r_miss_cnt;

  logic              w_sub;
  logic              w_pop;
  logic              w_drop;
  logic              w_capture;
  logic              w_head_zero;
  logic              w_held_zero;

  // ---------------------------------------------------------------------------
  // Aging tick: counter runs 0..TICK_DIV-1, pulse on the last count.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_sub       = (r_tick_cnt == TICK_LAST);
  assign w_head_zero = (q_data[KEY_W-1:0] == '0);
  assign w_held_zero = (r_task[KEY_W-1:0] == '0);

  // ---------------------------------------------------------------------------
  // Pop decision and next state.
  // A pop is blocked during the aging cycle so the queue never sees rd and
  // subtract together; it simply happens one cycle later. The reset term keeps
  // q_rd low while reset is asserted even if the queue is non-empty.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    w_pop        = 1'b0;
    w_drop       = 1'b0;
    w_capture    = 1'b0;
    w_state_next = r_state;

    w_pop = rst & enable & ~q_empty & ~w_sub &
            ((r_state == S_IDLE) | task_ready);
`ifdef DISPATCH_MISS_DROP_EN
    w_drop = w_pop & w_head_zero;
`endif
    w_capture = w_pop & ~w_drop;

    case (r_state)
      S_IDLE: begin
        if (w_capture) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        // Accepted with no replacement (none available, or it was dropped).
        if (task_ready && !w_capture) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Held task register. Capture takes priority over aging; only the key field
  // ages, saturating at zero, and only while a task is actually held.
  // ---------------------------------------------------------------------------
  // NOTE: the task register is reset so task_data reads 0 out of reset rather
  // than stale contents; it is a single word, not a memory array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_task <= '0;
    end else if (w_capture) begin
      r_task <= q_data;
    end else if (w_sub && (r_state == S_HOLD) && !w_held_zero) begin
      r_task[KEY_W-1:0] <= r_task[KEY_W-1:0] - 1'b1;
    end
  end

  // Miss counter: every pop of an already-expired task, dropped or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miss_cnt <= '0;
    end else if (w_pop && w_head_zero && (r_miss_cnt != 16'hFFFF)) begin
      r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign q_rd         = w_pop;
  assign q_subtract   = w_sub;
  assign task_data    = r_task;
  assign task_valid   = (r_state == S_HOLD);
  assign task_expired = (r_state == S_HOLD) & w_held_zero;
  assign miss_cnt     = r_miss_cnt;

endmodule
